// File: rtl/seg7_frame_decoder.sv
// Rebuilds a binary value from a frame of active-low gfedcba 7-segment digit codes, MSD first.
// Valid/ready on both sides; the result is held until the consumer accepts it.
module seg7_frame_decoder #(
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  input  logic             seg_valid,
  input  logic             seg_last,
  output logic             seg_ready,
  output logic [OUT_W-1:0] bin_out,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic             err
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 2);
  localparam int unsigned AccW = OUT_W + 4;

  typedef enum logic {StAcc, StOut} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             seen_q, seen_d;
  logic             err_q, err_d;

  logic             code_legal;
  logic             code_blank;
  logic [3:0]       code_val;
  logic [AccW-1:0]  acc_wide;
  logic [AccW-1:0]  acc_ext;
  logic             acc_ovf;
  logic             over_limit;
  logic             beat;

  always_comb begin
    code_legal = 1'b1;
    code_blank = 1'b0;
    code_val   = 4'd0;
    case (seg_in)
      7'b1000000: code_val = 4'd0;
      7'b1111001: code_val = 4'd1;
      7'b0100100: code_val = 4'd2;
      7'b0110000: code_val = 4'd3;
      7'b0011001: code_val = 4'd4;
      7'b0010010: code_val = 4'd5;
      7'b0000010: code_val = 4'd6;
      7'b1111000: code_val = 4'd7;
      7'b0000000: code_val = 4'd8;
      7'b0010000: code_val = 4'd9;
      7'b1111111: code_blank = 1'b1;
      default:    code_legal = 1'b0;
    endcase
  end

  // acc*10 + d, widened so the overflow bits are visible
  assign acc_wide   = {4'b0000, acc_q};
  assign acc_ext    = (acc_wide << 3) + (acc_wide << 1) + {{OUT_W{1'b0}}, code_val};
  assign acc_ovf    = |acc_ext[AccW-1:OUT_W];
  assign over_limit = (count_q >= CntW'(MAX_DIGITS));
  assign beat       = seg_valid && (state_q == StAcc);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    seen_d  = seen_q;
    err_d   = err_q;
    case (state_q)
      StAcc: begin
        if (beat) begin
          if (!over_limit) begin
            count_d = count_q + CntW'(1);
          end
          if (over_limit || !code_legal) begin
            err_d = 1'b1;
          end else if (code_blank) begin
            // a blank is only a leading zero until the first real digit
            if (seen_q) begin
              err_d = 1'b1;
            end
          end else begin
            seen_d = 1'b1;
            if (acc_ovf) begin
              err_d = 1'b1;
            end else begin
              acc_d = acc_ext[OUT_W-1:0];
            end
          end
          if (seg_last) begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (bin_ready) begin
          state_d = StAcc;
          acc_d   = '0;
          count_d = '0;
          seen_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StAcc;
      acc_q   <= '0;
      count_q <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    seg_ready = (state_q == StAcc);
    bin_valid = (state_q == StOut);
    err       = bin_valid && err_q;
    bin_out   = '0;
    if (bin_valid) begin
      bin_out = err_q ? {OUT_W{1'b1}} : acc_q;
    end
  end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Self-checking bench for seg7_frame_decoder: directed vector table, loopback sweep,
// multi-cycle corner sequences and random frames against a frame-level reference model.
module tb_seg7_frame_decoder;

  localparam int OUT_W      = 8;
  localparam int MAX_DIGITS = 3;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       seg_in;
  logic             seg_valid;
  logic             seg_last;
  logic             seg_ready;
  logic [OUT_W-1:0] bin_out;
  logic             bin_valid;
  logic             bin_ready;
  logic             err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         n;
    logic [6:0] c [4];
    int         v;
    bit         e;
  } vec_t;

  vec_t       vecs [11];
  logic [6:0] fr [8];
  int         fr_n;

  seg7_frame_decoder #(.OUT_W(OUT_W), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .seg_valid (seg_valid),
    .seg_last  (seg_last),
    .seg_ready (seg_ready),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // -1 illegal, -2 blank, else digit value
  function automatic int seg_value(input logic [6:0] c);
    for (int k = 0; k < 10; k++) if (c == SEG_TAB[k]) return k;
    if (c == BLANK) return -2;
    return -1;
  endfunction

  // Frame-level rule: the frame is a decimal number of at most MAX_DIGITS symbols,
  // leading blanks read as zeros, and the value must fit in OUT_W bits at every prefix.
  task automatic ref_frame(output int val, output bit e);
    bit seen = 0;
    val = 0;
    e   = 0;
    if (fr_n > MAX_DIGITS) e = 1;
    for (int i = 0; i < fr_n && i < MAX_DIGITS; i++) begin
      int d = seg_value(fr[i]);
      if (d == -1) e = 1;
      else if (d == -2) begin
        if (seen) e = 1;
      end else begin
        seen = 1;
        val  = val * 10 + d;
        if (val > (1 << OUT_W) - 1) e = 1;
      end
    end
  endtask

  // Sends fr[0..fr_n-1], checks the result, stalls `hold` cycles with junk beats, hands back.
  task automatic send_frame(input string nm, input int ev, input bit ee, input int hold);
    logic [31:0] exp_out;
    exp_out = ee ? 32'(2 ** OUT_W - 1) : 32'(ev);
    bin_ready = 1'b0;
    for (int i = 0; i < fr_n; i++) begin
      for (int k = 0; k < 20 && !seg_ready; k++) step();
      check($sformatf("%s seg_ready beat %0d", nm, i), 32'(seg_ready), 32'd1);
      check($sformatf("%s bin_valid early %0d", nm, i), 32'(bin_valid), 32'd0);
      seg_valid = 1'b1;
      seg_in    = fr[i];
      seg_last  = (i == fr_n - 1);
      step();
    end
    seg_valid = 1'b0;
    seg_last  = 1'b0;
    check({nm, " bin_valid"}, 32'(bin_valid), 32'd1);
    check({nm, " bin_out"}, 32'(bin_out), exp_out);
    check({nm, " err"}, 32'(err), 32'(ee));
    for (int h = 0; h < hold; h++) begin
      seg_valid = 1'b1;
      seg_in    = SEG_TAB[$urandom_range(0, 9)];
      seg_last  = 1'($urandom);
      step();
      check($sformatf("%s hold%0d seg_ready", nm, h), 32'(seg_ready), 32'd0);
      check($sformatf("%s hold%0d bin_valid", nm, h), 32'(bin_valid), 32'd1);
      check($sformatf("%s hold%0d bin_out", nm, h), 32'(bin_out), exp_out);
      check($sformatf("%s hold%0d err", nm, h), 32'(err), 32'(ee));
    end
    bin_ready = 1'b1;
    step();
    bin_ready = 1'b0;
    seg_valid = 1'b0;
    seg_last  = 1'b0;
    check({nm, " handback bin_valid"}, 32'(bin_valid), 32'd0);
    check({nm, " handback seg_ready"}, 32'(seg_ready), 32'd1);
  endtask

  task automatic set_vec(input int idx, input int n, input logic [6:0] c0, input logic [6:0] c1,
                         input logic [6:0] c2, input logic [6:0] c3, input int v, input bit e);
    vecs[idx].n    = n;
    vecs[idx].c[0] = c0;
    vecs[idx].c[1] = c1;
    vecs[idx].c[2] = c2;
    vecs[idx].c[3] = c3;
    vecs[idx].v    = v;
    vecs[idx].e    = e;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int rv;
    bit re;

    rst_n     = 1'b0;
    seg_in    = BLANK;
    seg_valid = 1'b0;
    seg_last  = 1'b0;
    bin_ready = 1'b0;

    set_vec(0, 2, 7'b0110000, 7'b1111001, BLANK, BLANK, 31, 0);
    set_vec(1, 3, SEG_TAB[2], SEG_TAB[5], SEG_TAB[5], BLANK, 255, 0);
    set_vec(2, 3, SEG_TAB[2], SEG_TAB[5], SEG_TAB[6], BLANK, 0, 1);
    set_vec(3, 2, BLANK, 7'b0100100, BLANK, BLANK, 2, 0);
    set_vec(4, 2, 7'b0100100, BLANK, BLANK, BLANK, 0, 1);
    set_vec(5, 3, SEG_TAB[1], 7'b0001000, SEG_TAB[3], BLANK, 0, 1);
    set_vec(6, 1, 7'b0001000, BLANK, BLANK, BLANK, 0, 1);
    set_vec(7, 4, SEG_TAB[1], SEG_TAB[2], SEG_TAB[3], SEG_TAB[4], 0, 1);
    set_vec(8, 1, SEG_TAB[7], BLANK, BLANK, BLANK, 7, 0);
    set_vec(9, 3, BLANK, BLANK, BLANK, BLANK, 0, 0);
    set_vec(10, 3, SEG_TAB[9], SEG_TAB[9], SEG_TAB[9], BLANK, 0, 1);

    step();
    step();
    check("reset seg_ready", 32'(seg_ready), 32'd1);
    check("reset bin_valid", 32'(bin_valid), 32'd0);
    check("reset bin_out", 32'(bin_out), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      fr_n = vecs[v].n;
      for (int i = 0; i < fr_n; i++) fr[i] = vecs[v].c[i];
      send_frame($sformatf("vec%0d", v), vecs[v].v, vecs[v].e, 0);
    end

    // Loopback of adder display values: leading blank below ten
    for (int r = 0; r < 32; r++) begin
      fr_n  = 2;
      fr[0] = (r < 10) ? BLANK : SEG_TAB[r / 10];
      fr[1] = SEG_TAB[r % 10];
      send_frame($sformatf("loop%0d", r), r, 0, 0);
    end

    // Long stall with junk beats, then a fresh frame must be untouched by them
    fr_n  = 2;
    fr[0] = SEG_TAB[4];
    fr[1] = SEG_TAB[2];
    send_frame("stall", 42, 0, 5);
    fr_n  = 1;
    fr[0] = SEG_TAB[5];
    send_frame("after_stall", 5, 0, 0);

    // Reset mid-frame
    seg_valid = 1'b1;
    seg_in    = SEG_TAB[1];
    seg_last  = 1'b0;
    step();
    seg_valid = 1'b0;
    do_reset();
    check("midrst seg_ready", 32'(seg_ready), 32'd1);
    check("midrst bin_valid", 32'(bin_valid), 32'd0);
    fr_n  = 1;
    fr[0] = 7'b0011001;
    send_frame("after_midrst", 4, 0, 0);

    // Reset while a result is pending
    seg_valid = 1'b1;
    seg_in    = SEG_TAB[9];
    seg_last  = 1'b1;
    step();
    seg_valid = 1'b0;
    seg_last  = 1'b0;
    check("outrst pending", 32'(bin_valid), 32'd1);
    do_reset();
    check("outrst bin_valid", 32'(bin_valid), 32'd0);
    check("outrst bin_out", 32'(bin_out), 32'd0);
    check("outrst seg_ready", 32'(seg_ready), 32'd1);
    fr_n  = 1;
    fr[0] = SEG_TAB[3];
    send_frame("after_outrst", 3, 0, 0);

    for (int t = 0; t < 200; t++) begin
      fr_n = $urandom_range(1, 5);
      for (int i = 0; i < fr_n; i++) begin
        int p = $urandom_range(0, 99);
        if (p < 72) fr[i] = SEG_TAB[$urandom_range(0, 9)];
        else if (p < 88) fr[i] = BLANK;
        else fr[i] = 7'($urandom);
      end
      ref_frame(rv, re);
      send_frame($sformatf("rnd%0d", t), rv, re, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
